// File: rtl/shift_arbiter_ctrl.sv
// Serial shift engine shared between a transmit and a receive requester.
// A round-robin flag picks the owner of the single shift register when both ask at once.
module shift_arbiter_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tx_valid,
    input  logic [N-1:0] tx_data,
    output logic         tx_ready,
    input  logic         rx_req,
    input  logic         serial_in,
    output logic         serial_out,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         tx_frame,
    output logic         rx_frame,
    output logic         busy
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_TX = 2'd1,
        SHIFT_RX = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   shreg_reg, shreg_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           prio_rx_reg, prio_rx_next;   // 1: rx side wins a tie
    logic [N-1:0]   rx_data_reg, rx_data_next;
    logic           rx_valid_reg, rx_valid_next;

    logic           is_idle;
    logic           rx_win;
    logic           tx_win;

    // rx only loses a tie when the flag favours tx; tx is "ready" whenever rx does not win.
    assign is_idle = (state_reg == IDLE);
    assign rx_win  = is_idle && rx_req && (!tx_valid || prio_rx_reg);
    assign tx_win  = is_idle && tx_valid && !rx_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            cnt_reg      <= '0;
            prio_rx_reg  <= 1'b0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            cnt_reg      <= cnt_next;
            prio_rx_reg  <= prio_rx_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        cnt_next      = cnt_reg;
        prio_rx_next  = prio_rx_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx_win) begin
                    shreg_next = tx_data;
                    cnt_next   = '0;
                    state_next = SHIFT_TX;
                    if (rx_req) prio_rx_next = 1'b1;
                end else if (rx_win) begin
                    cnt_next   = '0;
                    state_next = SHIFT_RX;
                    if (tx_valid) prio_rx_next = 1'b0;
                end
            end
            SHIFT_TX: begin
                shreg_next = {shreg_reg[N-2:0], 1'b0};
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BIT) state_next = IDLE;
            end
            SHIFT_RX: begin
                shreg_next = {shreg_reg[N-2:0], serial_in};
                cnt_next   = cnt_reg + 1'b1;
                // Only a completed word reaches rx_data; an aborted frame never does.
                if (cnt_reg == LAST_BIT) begin
                    rx_data_next  = {shreg_reg[N-2:0], serial_in};
                    rx_valid_next = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_ready   = is_idle && !rx_win;
    assign serial_out = (state_reg == SHIFT_TX) ? shreg_reg[N-1] : 1'b0;
    assign tx_frame   = (state_reg == SHIFT_TX);
    assign rx_frame   = (state_reg == SHIFT_RX);
    assign busy       = !is_idle;
    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;

endmodule
